// File: rtl/calc_pkg.sv
// Shared command definitions for calc_cmd_feeder and rec_calc.
package calc_pkg;

    localparam int DATA_W = 17;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_NOP = 4'd0;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] val;
    } calc_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// Small first-word-fall-through FIFO with wrap-bit pointers and a synchronous flush.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    // Flush wins over both a same-cycle push and a same-cycle pop.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
    end

endmodule

// File: rtl/calc_cmd_feeder.sv
// Buffers {op, operand} commands and issues them to rec_calc at a paced rate.
module calc_cmd_feeder #(
    parameter int DATA_W = calc_pkg::DATA_W,
    parameter int OP_W   = calc_pkg::OP_W,
    parameter int DEPTH  = 4,
    parameter int GAP    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [DATA_W-1:0]         in_val,
    output logic                      out_valid,
    output logic [OP_W-1:0]           out_op,
    output logic [DATA_W-1:0]         out_val,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [OP_W-1:0] NOP = OP_W'(calc_pkg::OP_NOP);

    logic [OP_W+DATA_W-1:0] head;
    logic                   full;
    logic                   empty;
    logic                   issue;

    logic [PW-1:0]     pace_cnt_reg,  pace_cnt_next;
    logic              out_valid_reg, out_valid_next;
    logic [OP_W-1:0]   out_op_reg,    out_op_next;
    logic [DATA_W-1:0] out_val_reg,   out_val_next;

    sync_fifo #(
        .WIDTH (OP_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (in_valid),
        .pop   (issue),
        .din   ({in_op, in_val}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign in_ready = !full;
    assign issue    = !empty && (pace_cnt_reg == '0) && !flush;

    // out_val deliberately holds across idle cycles so valA stays stable downstream.
    always_comb begin
        pace_cnt_next  = (pace_cnt_reg != '0) ? pace_cnt_reg - PW'(1) : '0;
        out_valid_next = 1'b0;
        out_op_next    = NOP;
        out_val_next   = out_val_reg;
        if (flush) begin
            pace_cnt_next = '0;
        end else if (issue) begin
            pace_cnt_next  = PW'(GAP - 1);
            out_valid_next = 1'b1;
            out_op_next    = head[OP_W+DATA_W-1:DATA_W];
            out_val_next   = head[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pace_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_op_reg    <= NOP;
            out_val_reg   <= '0;
        end else begin
            pace_cnt_reg  <= pace_cnt_next;
            out_valid_reg <= out_valid_next;
            out_op_reg    <= out_op_next;
            out_val_reg   <= out_val_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_op    = out_op_reg;
    assign out_val   = out_val_reg;

endmodule
